// File: rtl/tick_to_level.sv
// tick_to_level: turns one-cycle ticks into a level pulse of programmable
// width, followed by a minimum low gap before the next pulse may start.
// Moore FSM (IDLE -> HIGH -> GAP -> IDLE) with all outputs registered.
// Optional feature macro: TICK_TO_LEVEL_RETRIGGER_EN
//   defined   - a tick during HIGH reloads the pulse counter (pulse extends)
//   undefined - a tick during HIGH is ignored and flagged on drop
// The current FSM state is exported on state_dbg for observation.
module tick_to_level #(
    parameter int CNT_W      = 8,
    parameter int LOW_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [CNT_W-1:0] cfg_high_len,
    output logic             level,
    output logic             busy,
    output logic             drop,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        GAP  = 2'b10
    } state_t;

    // Reload value for the gap counter; only used when LOW_CYCLES > 0.
    localparam int               GAP_LOAD_I = (LOW_CYCLES > 0) ? LOW_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LOAD_I);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             drop_d;
    logic [CNT_W-1:0] pulse_load;

    // A zero length behaves as one cycle, so the reload never underflows.
    always_comb begin
        pulse_load = '0;
        if (cfg_high_len != '0) begin
            pulse_load = cfg_high_len - CNT_W'(1);
        end
    end

    // Next-state, counter and ignored-tick logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = HIGH;
                    cnt_d   = pulse_load;
                end
            end
            HIGH: begin
`ifdef TICK_TO_LEVEL_RETRIGGER_EN
                if (tick) begin
                    cnt_d = pulse_load;
                end else
`else
                drop_d = tick;
`endif
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (LOW_CYCLES > 0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                drop_d = tick;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                // Illegal encoding: recover to IDLE with a clean counter.
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset is asynchronous, active-low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level   <= 1'b0;
            busy    <= 1'b0;
            drop    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= (state_d == HIGH);
            busy    <= (state_d != IDLE);
            drop    <= drop_d;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_tick_to_level.sv
// Testbench for tick_to_level (CNT_W=8, LOW_CYCLES=2).
// Each scenario drives a tick pattern cycle by cycle and compares level,
// busy and drop against hand-computed bit vectors (bit i = cycle i, where
// cycle 0 is the cycle in which the first tick is presented).
module tb_tick_to_level;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             tick = 1'b0;
    logic [CNT_W-1:0] cfg_high_len = 8'd4;
    logic             level;
    logic             busy;
    logic             drop;
    logic [1:0]       state_dbg;

    int vec_cnt = 0;
    int err_cnt = 0;

    tick_to_level #(.CNT_W(CNT_W), .LOW_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .cfg_high_len (cfg_high_len),
        .level        (level),
        .busy         (busy),
        .drop         (drop),
        .state_dbg    (state_dbg)
    );

    // Clock: 10 time-unit period, first rising edge at t=5.
    always #5 clk = ~clk;

    // One cycle: drive tick just after the rising edge, then move to the
    // falling edge where outputs are sampled.
    task automatic cycle(input logic t);
        @(posedge clk);
        #1 tick = t;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_cnt++;
            if ({level, busy, drop} !== 3'b000 || state_dbg !== 2'b00) begin
                err_cnt++;
                $display("FAIL reset_hold cyc=%0d got l/b/d=%b%b%b st=%b want 000 st=00",
                         i, level, busy, drop, state_dbg);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0);
            vec_cnt++;
            if ({level, busy, drop} !== 3'b000) begin
                err_cnt++;
                $display("FAIL reset_idle cyc=%0d got l/b/d=%b%b%b want 000",
                         i, level, busy, drop);
            end
        end
    endtask

    // Ticks at 0 and 7 with length 4: pulses at 1..4 and 8..11.
    task automatic test_single_pulse();
        logic [15:0] tk   = 16'h0081;
        logic [15:0] lv_e = 16'h0F1E;
        logic [15:0] bz_e = 16'h3F7E;
        cfg_high_len = 8'd4;
        for (int i = 0; i < 16; i++) begin
            cycle(tk[i]);
            vec_cnt++;
            if (level !== lv_e[i] || busy !== bz_e[i] || drop !== 1'b0) begin
                err_cnt++;
                $display("FAIL single_pulse cyc=%0d got l/b/d=%b%b%b want %b%b0",
                         i, level, busy, drop, lv_e[i], bz_e[i]);
            end
        end
    endtask

    // Length 0 behaves as 1: level at cycle 1 only, gap at 2..3.
    task automatic test_zero_length();
        logic [7:0] lv_e = 8'h02;
        logic [7:0] bz_e = 8'h0E;
        cfg_high_len = 8'd0;
        for (int i = 0; i < 8; i++) begin
            cycle(i == 0);
            vec_cnt++;
            if (level !== lv_e[i] || busy !== bz_e[i] || drop !== 1'b0) begin
                err_cnt++;
                $display("FAIL zero_length cyc=%0d got l/b/d=%b%b%b want %b%b0",
                         i, level, busy, drop, lv_e[i], bz_e[i]);
            end
        end
    endtask

    // Length changed mid-pulse must not alter the running pulse (1..4).
    task automatic test_cfg_change();
        logic [9:0] lv_e = 10'h01E;
        logic [9:0] bz_e = 10'h07E;
        cfg_high_len = 8'd4;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) cfg_high_len = 8'd1;
            if (i == 3) cfg_high_len = 8'd9;
            cycle(i == 0);
            vec_cnt++;
            if (level !== lv_e[i] || busy !== bz_e[i] || drop !== 1'b0) begin
                err_cnt++;
                $display("FAIL cfg_change cyc=%0d got l/b/d=%b%b%b want %b%b0",
                         i, level, busy, drop, lv_e[i], bz_e[i]);
            end
        end
        cfg_high_len = 8'd4;
    endtask

    // Ticks at 5 and 6 fall in the gap: dropped, flagged at 6 and 7.
    task automatic test_gap_drop();
        logic [11:0] tk   = 12'h061;
        logic [11:0] lv_e = 12'h01E;
        logic [11:0] bz_e = 12'h07E;
        logic [11:0] dr_e = 12'h0C0;
        cfg_high_len = 8'd4;
        for (int i = 0; i < 12; i++) begin
            cycle(tk[i]);
            vec_cnt++;
            if (level !== lv_e[i] || busy !== bz_e[i] || drop !== dr_e[i]) begin
                err_cnt++;
                $display("FAIL gap_drop cyc=%0d got l/b/d=%b%b%b want %b%b%b",
                         i, level, busy, drop, lv_e[i], bz_e[i], dr_e[i]);
            end
        end
    endtask

    // Ticks at 0 and 3 with length 4: extend or drop depending on the build.
    task automatic test_retrigger();
        logic [11:0] tk = 12'h009;
`ifdef TICK_TO_LEVEL_RETRIGGER_EN
        logic [11:0] lv_e = 12'h0FE;
        logic [11:0] bz_e = 12'h3FE;
        logic [11:0] dr_e = 12'h000;
`else
        logic [11:0] lv_e = 12'h01E;
        logic [11:0] bz_e = 12'h07E;
        logic [11:0] dr_e = 12'h010;
`endif
        cfg_high_len = 8'd4;
        for (int i = 0; i < 12; i++) begin
            cycle(tk[i]);
            vec_cnt++;
            if (level !== lv_e[i] || busy !== bz_e[i] || drop !== dr_e[i]) begin
                err_cnt++;
                $display("FAIL retrigger cyc=%0d got l/b/d=%b%b%b want %b%b%b",
                         i, level, busy, drop, lv_e[i], bz_e[i], dr_e[i]);
            end
        end
    endtask

    // Reset asserted between edges mid-pulse clears outputs immediately;
    // afterwards a tick gives a full-length pulse.
    task automatic test_async_reset();
        logic [9:0] lv_e = 10'h01E;
        logic [9:0] bz_e = 10'h07E;
        cfg_high_len = 8'd4;
        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0);
        vec_cnt++;
        if (level !== 1'b1) begin
            err_cnt++;
            $display("FAIL async_pre level got %b want 1", level);
        end
        #1 reset = 1'b0;
        #1;
        vec_cnt++;
        if (level !== 1'b0 || busy !== 1'b0 || drop !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_now got l/b/d=%b%b%b want 000", level, busy, drop);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(i == 0);
            vec_cnt++;
            if (level !== lv_e[i] || busy !== bz_e[i] || drop !== 1'b0) begin
                err_cnt++;
                $display("FAIL async_after cyc=%0d got l/b/d=%b%b%b want %b%b0",
                         i, level, busy, drop, lv_e[i], bz_e[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_zero_length();
        test_cfg_change();
        test_gap_drop();
        test_retrigger();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
